// File: rtl/exc_pkg.sv
// -----------------------------------------------------------------------------
// exc_pkg
// Shared types and helpers for the exception unit.
//   exc_code_t : trap codes carried on the exception vector to privileged_regs
//   stage_t    : pipeline stage index, oldest (MEM) has the highest value
//   state_t    : exception_unit FSM states
//   trap_t     : one selected trap candidate (valid, stage, code, pc, addr, info)
//   flush_mask : per-stage flush bits {MEM,EX,ID,IF} for a trap raised in a stage
//   pack_info  : additional-info word for non-ILLEGAL traps
// -----------------------------------------------------------------------------
package exc_pkg;

    typedef enum logic [2:0] {
        EXC_NONE       = 3'd0,
        EXC_ITLB       = 3'd1,
        EXC_DTLB       = 3'd2,
        EXC_ILLEGAL    = 3'd3,
        EXC_MISALIGNED = 3'd4,
        EXC_PRIV       = 3'd5
    } exc_code_t;

    typedef enum logic [1:0] {
        STG_IF  = 2'd0,
        STG_ID  = 2'd1,
        STG_EX  = 2'd2,
        STG_MEM = 2'd3
    } stage_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REPORT,
        ST_HANDLER
    } state_t;

    // The MEM code is passed through unchanged and may hold values outside
    // exc_code_t, so the code field is kept as a plain 3-bit vector.
    typedef struct packed {
        logic        valid;
        stage_t      stage;
        logic [2:0]  code;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] info;
    } trap_t;

    // Flush applied on iret: squash IF and ID so fetch restarts at the
    // return address held in rm0.
    localparam logic [3:0] FLUSH_REDIRECT = 4'b0011;

    // A trap in stage s kills that instruction and everything younger,
    // i.e. flush bits [s:0].
    function automatic logic [3:0] flush_mask(input stage_t s);
        logic [3:0] m;
        unique case (s)
            STG_IF:  m = 4'b0001;
            STG_ID:  m = 4'b0011;
            STG_EX:  m = 4'b0111;
            STG_MEM: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] pack_info(input stage_t s, input logic [2:0] code);
        return {27'b0, s, code};
    endfunction

endpackage

// File: rtl/exc_prio_sel.sv
// -----------------------------------------------------------------------------
// exc_prio_sel
// Combinational oldest-first selector over the four pipeline fault sources.
// Priority MEM > EX > ID > IF; a losing (younger) report is dropped because
// the winning trap flushes that instruction anyway.
// Ports:
//   if_valid_i, if_pc_i                  IF ITLB miss and fetch PC
//   id_valid_i, id_pc_i, id_instr_i      ID illegal instruction, PC, word
//   ex_priv_op_i, ex_pc_i, supervisor_i  privileged op in EX, PC, current mode
//   mem_valid_i, mem_code_i, mem_pc_i,
//   mem_addr_i                           MEM fault, code, PC, data address
//   sel_o                                selected trap (valid=0 when none)
// -----------------------------------------------------------------------------
module exc_prio_sel
    import exc_pkg::*;
(
    input  logic        if_valid_i,
    input  logic [31:0] if_pc_i,
    input  logic        id_valid_i,
    input  logic [31:0] id_pc_i,
    input  logic [31:0] id_instr_i,
    input  logic        ex_priv_op_i,
    input  logic [31:0] ex_pc_i,
    input  logic        supervisor_i,
    input  logic        mem_valid_i,
    input  logic [2:0]  mem_code_i,
    input  logic [31:0] mem_pc_i,
    input  logic [31:0] mem_addr_i,
    output trap_t       sel_o
);

    // A privileged op only traps when executed from user mode.
    logic ex_trap;
    assign ex_trap = ex_priv_op_i & ~supervisor_i;

    always_comb begin
        // NOTE: every field gets a default first so no path leaves a latch.
        sel_o = '0;
        if (mem_valid_i) begin
            sel_o.valid = 1'b1;
            sel_o.stage = STG_MEM;
            sel_o.code  = mem_code_i;
            sel_o.pc    = mem_pc_i;
            sel_o.addr  = mem_addr_i;
            sel_o.info  = pack_info(STG_MEM, mem_code_i);
        end else if (ex_trap) begin
            sel_o.valid = 1'b1;
            sel_o.stage = STG_EX;
            sel_o.code  = EXC_PRIV;
            sel_o.pc    = ex_pc_i;
            sel_o.addr  = '0;
            sel_o.info  = pack_info(STG_EX, EXC_PRIV);
        end else if (id_valid_i) begin
            sel_o.valid = 1'b1;
            sel_o.stage = STG_ID;
            sel_o.code  = EXC_ILLEGAL;
            sel_o.pc    = id_pc_i;
            sel_o.addr  = '0;
            // The handler decodes the offending word itself.
            sel_o.info  = id_instr_i;
        end else if (if_valid_i) begin
            sel_o.valid = 1'b1;
            sel_o.stage = STG_IF;
            sel_o.code  = EXC_ITLB;
            sel_o.pc    = if_pc_i;
            sel_o.addr  = if_pc_i;
            sel_o.info  = pack_info(STG_IF, EXC_ITLB);
        end
    end

endmodule

// File: rtl/exception_unit.sv
// -----------------------------------------------------------------------------
// exception_unit
// Producer side of the trap interface into privileged_regs. Picks the oldest
// pipeline fault, flushes the pipeline for FLUSH_CYCLES cycles, then pulses
// the exception vector with fault PC/address/info for exactly one cycle.
// Stays busy until the handler returns (iret); a trap raised while the
// handler runs sets a sticky double-fault flag instead of being reported.
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   in_stall                 pipeline stalled, no new trap accepted
//   in_supervisor_mode       current mode; privileged ops trap in user mode
//   in_iret                  handler return committing this cycle
//   in_if_* / in_id_* /
//   in_ex_* / in_mem_*       per-stage fault reports
//   out_exception_vector     trap code, nonzero for one cycle
//   out_fault_pc/addr        faulting PC / address, valid with the vector
//   out_additional_info      instruction word (ILLEGAL) or {stage, code}
//   out_flush                per-stage flush {MEM,EX,ID,IF}
//   out_kill_mem_write       same-cycle store suppression for a MEM fault
//   out_busy                 trap in progress (not IDLE)
//   out_double_fault         sticky until reset
// -----------------------------------------------------------------------------
module exception_unit
    import exc_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_stall,
    input  logic        in_supervisor_mode,
    input  logic        in_iret,
    input  logic        in_if_exc_valid,
    input  logic [31:0] in_if_pc,
    input  logic        in_id_exc_valid,
    input  logic [31:0] in_id_pc,
    input  logic [31:0] in_id_instr,
    input  logic        in_ex_priv_op,
    input  logic [31:0] in_ex_pc,
    input  logic        in_mem_exc_valid,
    input  logic [2:0]  in_mem_exc_code,
    input  logic [31:0] in_mem_pc,
    input  logic [31:0] in_mem_addr,
    output logic [2:0]  out_exception_vector,
    output logic [31:0] out_fault_pc,
    output logic [31:0] out_fault_addr,
    output logic [31:0] out_additional_info,
    output logic [3:0]  out_flush,
    output logic        out_kill_mem_write,
    output logic        out_busy,
    output logic        out_double_fault
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;

    // Capture registers, loaded when a trap is accepted in IDLE.
    logic [2:0]         cap_code_q;
    logic [31:0]        cap_pc_q;
    logic [31:0]        cap_addr_q;
    logic [31:0]        cap_info_q;

    // Registered outputs.
    logic [2:0]         vec_q;
    logic [31:0]        fault_pc_q;
    logic [31:0]        fault_addr_q;
    logic [31:0]        info_q;
    logic [3:0]         flush_q;
    logic               dbl_q;

    trap_t              sel;

    exc_prio_sel u_prio_sel (
        .if_valid_i   (in_if_exc_valid),
        .if_pc_i      (in_if_pc),
        .id_valid_i   (in_id_exc_valid),
        .id_pc_i      (in_id_pc),
        .id_instr_i   (in_id_instr),
        .ex_priv_op_i (in_ex_priv_op),
        .ex_pc_i      (in_ex_pc),
        .supervisor_i (in_supervisor_mode),
        .mem_valid_i  (in_mem_exc_valid),
        .mem_code_i   (in_mem_exc_code),
        .mem_pc_i     (in_mem_pc),
        .mem_addr_i   (in_mem_addr),
        .sel_o        (sel)
    );

    // Must act in the same cycle the faulting store sits in MEM, so this
    // path is deliberately combinational. Outside IDLE the pipeline is
    // already being flushed or the handler is running.
    assign out_kill_mem_write = in_mem_exc_valid & (state_q == ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            cap_code_q   <= '0;
            cap_pc_q     <= '0;
            cap_addr_q   <= '0;
            cap_info_q   <= '0;
            vec_q        <= '0;
            fault_pc_q   <= '0;
            fault_addr_q <= '0;
            info_q       <= '0;
            flush_q      <= '0;
            dbl_q        <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register sees the pre-edge value of every other one.
            // Report outputs are single-cycle pulses; cleared unless REPORT
            // is being entered below.
            vec_q        <= '0;
            fault_pc_q   <= '0;
            fault_addr_q <= '0;
            info_q       <= '0;

            unique case (state_q)
                ST_IDLE: begin
                    if (sel.valid && !in_stall) begin
                        cap_code_q <= sel.code;
                        cap_pc_q   <= sel.pc;
                        cap_addr_q <= sel.addr;
                        cap_info_q <= sel.info;
                        flush_q    <= flush_mask(sel.stage);
                        cnt_q      <= CNT_W'(FLUSH_CYCLES - 1);
                        state_q    <= ST_FLUSH;
                    end else begin
                        // Also ends the one-cycle redirect flush after iret.
                        flush_q <= '0;
                    end
                end

                ST_FLUSH: begin
                    // Trap inputs are ignored: everything behind the faulting
                    // instruction is being squashed.
                    if (cnt_q == '0) begin
                        flush_q      <= '0;
                        vec_q        <= cap_code_q;
                        fault_pc_q   <= cap_pc_q;
                        fault_addr_q <= cap_addr_q;
                        info_q       <= cap_info_q;
                        state_q      <= ST_REPORT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                ST_REPORT: begin
                    state_q <= ST_HANDLER;
                end

                ST_HANDLER: begin
                    // iret wins over a simultaneous trap: the trapping
                    // instruction is younger than the return.
                    if (in_iret) begin
                        flush_q <= FLUSH_REDIRECT;
                        state_q <= ST_IDLE;
                    end else if (sel.valid) begin
                        dbl_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign out_exception_vector = vec_q;
    assign out_fault_pc         = fault_pc_q;
    assign out_fault_addr       = fault_addr_q;
    assign out_additional_info  = info_q;
    assign out_flush            = flush_q;
    assign out_busy             = (state_q != ST_IDLE);
    assign out_double_fault     = dbl_q;

endmodule
